ext_alu_seq: RTL
================

# ext_alu_seq

Multi-cycle issue/retire sequencer wrapped around the extended ALU in the EX stage. Accepts an extended-op request from ID/EX, holds the operands and function code stable on the ALU inputs for the op's fixed latency, stalls the front of the pipeline meanwhile, then captures the result and flags into the registers that feed EX/DM. Also handles flush, illegal function codes and back-to-back issue.

## Interface
- DATA_W, 16, operand/result width
- LAT_MUL, 2, cycles for MUL/UMUL (func 000/001)
- LAT_ADDF, 3, cycles for ADDF/SUBF (010/011)
- LAT_MULF, 3, cycles for MULF (100)
- LAT_CVT, 1, cycles for ITF/FTI (101/110)
- All LAT_* are 1..8.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  extended-op request valid from ID/EX
- func  in  3  op code, encoding as the extended ALU
- src1, src0  in  DATA_W  operands
- flush  in  1  synchronous abort of the in-flight op
- alu_src1, alu_src0  out  DATA_W  registered operands to the extended ALU
- alu_func  out  3  registered func to the extended ALU
- alu_dst  in  DATA_W  ALU result
- alu_ov, alu_zr, alu_neg  in  1  ALU flags
- stall  out  1  hold IF/ID/EX
- done  out  1  one-cycle pulse: dst/flags updated this cycle
- dst_EX_DM  out  DATA_W  captured result
- ov, zr, neg  out  1  captured flags
- illegal  out  1  one-cycle pulse: func 111 rejected
- busy_cycles  out  16  stall-cycle counter (see Configuration)

## Operation
- FSM states IDLE, BUSY. Reset -> IDLE; every output and register is 0.
- IDLE, start=1, flush=0, func≠111: latch src1/src0/func into alu_* regs, load cnt = LAT(func)−1, go BUSY.
- IDLE, start=1, func=111: stay IDLE, pulse illegal next cycle. dst_EX_DM and flags unchanged. done not pulsed.
- IDLE, start=1, flush=1: request dropped.
- BUSY, cnt≠0: cnt decrements. alu_* regs hold.
- BUSY, cnt=0: capture alu_dst→dst_EX_DM and alu_ov/zr/neg→ov/zr/neg, pulse done next cycle, go IDLE.
- BUSY, flush=1: go IDLE, no capture, no done. Flush has priority over completion in the same cycle.
- start while BUSY is ignored; upstream holds it because stall=1.
- alu_* regs keep their last values in IDLE (no toggling).
- stall = (IDLE & start & ~flush & func≠111) | (BUSY & ~flush). Combinational.

## Timing
- start sampled at end of cycle 0. BUSY cycles 1..LAT. Capture at the end of cycle LAT. done and new dst/flags are visible in cycle LAT+1.
- stall is high in cycles 0..LAT and low in LAT+1.
- Back-to-back: a new start in cycle LAT+1 is accepted, so issue throughput is one op per LAT+1 cycles.
- illegal pulses in cycle 1 for a func=111 start in cycle 0. stall stays low.
- rst mid-op: next cycle is IDLE with all outputs 0. No done.
- cnt is 3 bits and never wraps: it is only loaded from IDLE.

## Configuration
- EXT_ALU_BUSY_CNT_EN defined: busy_cycles is a 16-bit register, cleared by rst, incremented each cycle stall=1, saturating at 0xFFFF.
- Not defined: busy_cycles tied to 0 and no counter logic is synthesised.

## Test plan
- MUL src1=0x0003, src0=0xFFFE (bench ALU model) -> stall high in cycles 0–2; done in cycle 3; dst_EX_DM=0xFFFA, neg=1, zr=0, ov=0.
- ADDF then ITF issued back-to-back, each in the cycle after the previous done -> done in cycles 4 and 6; results in order.
- func=111 -> illegal=1 in cycle 1, stall never high, dst/flags keep their prior values, no done.
- MULF with flush in cycle 2 -> IDLE in cycle 3, no done, dst unchanged. Flush coincident with cnt=0 -> no capture.
- rst asserted in cycle 1 of an ADDF -> cycle 2 all outputs 0, FSM in IDLE; a new start then behaves normally.
- With EXT_ALU_BUSY_CNT_EN: run MUL+ADDF -> busy_cycles=7. Preload near 0xFFFF -> saturates. Without the macro -> busy_cycles stays 0.

Source files
------------

// File: rtl/ext_alu_seq.sv
// Issue/retire sequencer for the multi-cycle extended ALU: holds operands for the op latency,
// stalls the front end, captures result/flags. Optional stall counter under EXT_ALU_BUSY_CNT_EN.
module ext_alu_seq #(
   parameter int DATA_W   = 16,
   parameter int LAT_MUL  = 2,
   parameter int LAT_ADDF = 3,
   parameter int LAT_MULF = 3,
   parameter int LAT_CVT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        func,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src0,
   input  logic              flush,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src0,
   output logic [2:0]        alu_func,
   input  logic [DATA_W-1:0] alu_dst,
   input  logic              alu_ov,
   input  logic              alu_zr,
   input  logic              alu_neg,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] dst_EX_DM,
   output logic              ov,
   output logic              zr,
   output logic              neg,
   output logic              illegal,
   output logic [15:0]       busy_cycles
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [2:0] FUNC_ILL = 3'b111;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       accept, capture, ill_req;

   // Count value is latency-1: the final BUSY cycle is the one that sees cnt==0.
   function automatic logic [2:0] lat_m1(input logic [2:0] f);
      case (f)
         3'b000, 3'b001: lat_m1 = 3'(LAT_MUL - 1);
         3'b010, 3'b011: lat_m1 = 3'(LAT_ADDF - 1);
         3'b100:         lat_m1 = 3'(LAT_MULF - 1);
         default:        lat_m1 = 3'(LAT_CVT - 1);
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      ill_req   = 1'b0;
      case (state)
         IDLE: begin
            // An illegal code is reported even if the same cycle is flushed.
            if (start && func == FUNC_ILL) begin
               ill_req = 1'b1;
            end else if (start && !flush) begin
               accept    = 1'b1;
               stall     = 1'b1;
               cnt_nxt   = lat_m1(func);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               stall = 1'b1;
               if (cnt == 3'd0) begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt - 3'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_src1  <= '0;
         alu_src0  <= '0;
         alu_func  <= '0;
         dst_EX_DM <= '0;
         ov        <= 1'b0;
         zr        <= 1'b0;
         neg       <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         done    <= capture;
         illegal <= ill_req;
         if (accept) begin
            alu_src1 <= src1;
            alu_src0 <= src0;
            alu_func <= func;
         end
         if (capture) begin
            dst_EX_DM <= alu_dst;
            ov        <= alu_ov;
            zr        <= alu_zr;
            neg       <= alu_neg;
         end
      end
   end

`ifdef EXT_ALU_BUSY_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         busy_cycles <= '0;
      else if (stall && busy_cycles != 16'hFFFF)
         busy_cycles <= busy_cycles + 16'd1;
   end
`else
   assign busy_cycles = '0;
`endif

endmodule
